// File: rtl/shared_unit_pkg.sv
// Shared definitions for the round-robin arithmetic-unit scheduler:
// state encodings and the operand-slice index helper.
package shared_unit_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/shared_unit_sched_rr_select.sv
// Combinational round-robin selector: first set request bit at ptr, ptr+1, ...
// wrapping modulo N.
module rr_select #(
    parameter  int unsigned N  = 4,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          any,
    output logic [PW-1:0] winner,
    output logic [N-1:0]  onehot
);

    int unsigned idx;

    always_comb begin
        any    = 1'b0;
        winner = '0;
        onehot = '0;
        idx    = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (!any && req[idx]) begin
                any         = 1'b1;
                winner      = PW'(idx);
                onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_unit_sched.sv
// Shares one adder between N requesters with rotating priority; each operation
// occupies the unit for LAT cycles and ends with a one-cycle done pulse.
module shared_unit_sched
    import shared_unit_pkg::*;
#(
    parameter int unsigned N   = 4,
    parameter int unsigned W   = 4,
    parameter int unsigned LAT = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] a_bus,
    input  logic [N*W-1:0] b_bus,
    output logic [N-1:0]   grant,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   result
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;

    if (LAT < 1) begin : g_bad_lat
        $error("shared_unit_sched: LAT must be at least 1");
    end
    if (N < 2 || N > 8) begin : g_bad_n
        $error("shared_unit_sched: N must be in 2..8");
    end

    logic [1:0]    state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] win_q;
    logic [CW-1:0] cnt;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;

    logic          sel_any;
    logic [PW-1:0] sel_winner;
    logic [N-1:0]  sel_onehot;

    rr_select #(.N(N)) u_rr_select (
        .req    (req),
        .ptr    (ptr),
        .any    (sel_any),
        .winner (sel_winner),
        .onehot (sel_onehot)
    );

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            grant  <= '0;
            done   <= 1'b0;
            result <= '0;
            ptr    <= '0;
            win_q  <= '0;
            cnt    <= '0;
            op_a   <= '0;
            op_b   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sel_any) begin
                        op_a  <= a_bus[slice_lo(32'(sel_winner), W) +: W];
                        op_b  <= b_bus[slice_lo(32'(sel_winner), W) +: W];
                        grant <= sel_onehot;
                        win_q <= sel_winner;
                        cnt   <= CW'(LAT - 1);
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        // Carry out of the W-bit sum is intentionally dropped.
                        result <= op_a + op_b;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    grant <= '0;
                    ptr   <= (win_q == PW'(N - 1)) ? '0 : win_q + PW'(1);
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
    a_done_busy:     assert property (@(posedge clk) disable iff (!rst_n) done |-> busy);
    a_grant_busy:    assert property (@(posedge clk) disable iff (!rst_n) (grant != '0) == busy);
    a_state_legal:   assert property (@(posedge clk) disable iff (!rst_n) state != 2'd3);

endmodule

// File: tb/tb_shared_unit_sched.sv
// Directed testbench for shared_unit_sched: default instance (N=4,W=4,LAT=3)
// plus an overridden instance (N=2,W=8,LAT=1).
module tb_shared_unit_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] a_bus, b_bus;
    logic [3:0]  grant;
    logic        busy, done;
    logic [3:0]  result;

    logic [1:0]  req2;
    logic [15:0] a_bus2, b_bus2;
    logic [1:0]  grant2;
    logic        busy2, done2;
    logic [7:0]  result2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shared_unit_sched #(.N(4), .W(4), .LAT(3)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a_bus(a_bus), .b_bus(b_bus),
        .grant(grant), .busy(busy), .done(done), .result(result)
    );

    shared_unit_sched #(.N(2), .W(8), .LAT(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req2), .a_bus(a_bus2), .b_bus(b_bus2),
        .grant(grant2), .busy(busy2), .done(done2), .result(result2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [3:0] a, input logic [3:0] b);
        a_bus[i*4 +: 4] = a;
        b_bus[i*4 +: 4] = b;
    endtask

    // Present r, expect grant g at the next edge, done LAT=3 cycles later with
    // result res, then an IDLE cycle once the request is withdrawn.
    task automatic run_op(input string tag, input logic [3:0] r, input logic [3:0] g,
                          input logic [3:0] res);
        int cycles;
        req = r;
        step();
        check({tag, "_grant"}, 32'(grant), 32'(g));
        check({tag, "_busy"}, 32'(busy), 32'd1);
        cycles = 0;
        while (!done && cycles < 20) begin
            step();
            cycles++;
        end
        check({tag, "_latency"}, cycles, 32'd3);
        check({tag, "_result"}, 32'(result), 32'(res));
        check({tag, "_grant_at_done"}, 32'(grant), 32'(g));
        req = '0;
        step();
        check({tag, "_idle_grant"}, 32'(grant), 32'd0);
        check({tag, "_idle_done"}, 32'(done), 32'd0);
        check({tag, "_idle_result"}, 32'(result), 32'(res));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] exp_g [5];
        rst_n = 1'b0;
        req = '0; a_bus = '0; b_bus = '0;
        req2 = '0; a_bus2 = '0; b_bus2 = '0;
        do_reset();

        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst2_grant", 32'(grant2), 32'd0);
        check("rst2_result", 32'(result2), 32'd0);

        // Single request; ptr afterwards = 2, so 0101 picks requester 2.
        set_ops(1, 4'd3, 4'd4);
        run_op("single", 4'b0010, 4'b0010, 4'd7);
        set_ops(2, 4'd5, 4'd6);
        run_op("ptr2", 4'b0101, 4'b0100, 4'd11);

        // Carry dropped: F + 2 = 1.
        set_ops(0, 4'hF, 4'h2);
        run_op("wrap", 4'b0001, 4'b0001, 4'h1);

        // Fairness from ptr=0 with all requests held.
        do_reset();
        for (int i = 0; i < 4; i++) set_ops(i, 4'(i), 4'd1);
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
        exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            step();
            check($sformatf("fair%0d_grant", n), 32'(grant), 32'(exp_g[n]));
            step();
            step();
            step();
            check($sformatf("fair%0d_done", n), 32'(done), 32'd1);
            check($sformatf("fair%0d_result", n), 32'(result), 32'((n % 4) + 1));
            if (n == 4) req = '0;
            step();
            check($sformatf("fair%0d_gap", n), 32'(grant), 32'd0);
            check($sformatf("fair%0d_gap_busy", n), 32'(busy), 32'd0);
        end

        // Priority rotation: serve 3 (ptr->0), then 1001 twice.
        set_ops(3, 4'd2, 4'd2);
        run_op("rot3", 4'b1000, 4'b1000, 4'd4);
        set_ops(0, 4'd1, 4'd1);
        run_op("rot_a", 4'b1001, 4'b0001, 4'd2);
        run_op("rot_b", 4'b1001, 4'b1000, 4'd4);

        // Move ptr to 2, then reset mid-operation (cnt=1).
        run_op("pre_rst", 4'b0010, 4'b0010, 4'd2);
        set_ops(2, 4'd7, 4'd7);
        req = 4'b0100;
        step();
        check("mid_grant", 32'(grant), 32'b0100);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_grant", 32'(grant), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_result", 32'(result), 32'd0);
        req = '0;
        #1;
        rst_n = 1'b1;
        step();
        for (int n = 0; n < 5; n++) begin
            check($sformatf("post_rst_nodone%0d", n), 32'(done), 32'd0);
            step();
        end
        set_ops(1, 4'd6, 4'd1);
        run_op("post_rst", 4'b0110, 4'b0010, 4'd7);

        // Overridden instance: N=2, W=8, LAT=1; 200+100 = 300 mod 256 = 44.
        a_bus2[7:0] = 8'd200;
        b_bus2[7:0] = 8'd100;
        req2 = 2'b01;
        step();
        check("ovr_grant", 32'(grant2), 32'b01);
        check("ovr_done_early", 32'(done2), 32'd0);
        step();
        check("ovr_done", 32'(done2), 32'd1);
        check("ovr_result", 32'(result2), 32'd44);
        req2 = '0;
        step();
        check("ovr_idle_grant", 32'(grant2), 32'd0);
        check("ovr_idle_done", 32'(done2), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
